// File: rtl/glitch_pkg.sv
// glitch_pkg
// Shared definitions for the glitch pulse generator and the UART command
// handler that programs it: configuration field widths, the generator
// state encoding and a small helper for loading down-counters.
package glitch_pkg;

  localparam int DELAY_W      = 16;
  localparam int WIDTH_W      = 8;
  localparam int NUM_PULSES_W = 8;
  localparam int SPACING_W    = 16;
  localparam int PHASE_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_PULSE,
    ST_SPACE,
    ST_DONE
  } state_t;

  // A phase that lasts n cycles counts n-1 down to 0. Saturates so a zero
  // request can never wrap the counter.
  function automatic logic [PHASE_W-1:0] cycles_to_phase(input logic [PHASE_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a flop chain and
// emits a registered one-cycle strobe on its rising edge.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_async  asynchronous input level
//   o_rise   one-cycle strobe, high the cycle after a synchronized 0->1
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // Synchronizer chain, previous-value flop and registered edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen
// Arms on a level enable, waits for a rising edge on the external target
// trigger, counts out a programmed delay and then drives a train of glitch
// pulses. The glitch output comes straight from a flop so the downstream
// crowbar/clock-glitch driver never sees combinational hazards.
// Ports:
//   clk              system clock
//   rst              asynchronous active-high reset
//   trigger_i        target trigger, asynchronous to clk
//   arm_i            level enable; dropping it aborts a running train
//   delay_i          cycles from trigger detection to first pulse
//   width_i          high cycles per pulse
//   num_pulses_i     pulses per trigger
//   pulse_spacing_i  low cycles between pulses
//   glitch_o         registered glitch output
//   busy_o           high while delaying or emitting the train
//   done_o           one-cycle strobe after a completed train
module glitch_pulse_gen
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger_i,
  input  logic                    arm_i,
  input  logic [DELAY_W-1:0]      delay_i,
  input  logic [WIDTH_W-1:0]      width_i,
  input  logic [NUM_PULSES_W-1:0] num_pulses_i,
  input  logic [SPACING_W-1:0]    pulse_spacing_i,
  output logic                    glitch_o,
  output logic                    busy_o,
  output logic                    done_o
);

  state_t                  r_state;
  logic [PHASE_W-1:0]      r_phase;
  logic [NUM_PULSES_W-1:0] r_pulses;
  logic [DELAY_W-1:0]      r_delay;
  logic [WIDTH_W-1:0]      r_width;
  logic [NUM_PULSES_W-1:0] r_num;
  logic [SPACING_W-1:0]    r_spacing;
  logic                    r_glitch;
  logic                    r_busy;
  logic                    r_done;

  state_t                  w_next_state;
  logic [PHASE_W-1:0]      w_next_phase;
  logic [NUM_PULSES_W-1:0] w_next_pulses;
  logic                    w_latch;
  logic                    w_rise;
  logic [DELAY_W-1:0]      w_delay;
  logic [WIDTH_W-1:0]      w_width;
  logic [NUM_PULSES_W-1:0] w_num;
  logic [SPACING_W-1:0]    w_spacing;
  logic                    w_no_train;
  logic [PHASE_W-1:0]      w_width_load;
  logic [PHASE_W-1:0]      w_spacing_load;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_trig (
    .clk     (clk),
    .rst     (rst),
    .i_async (trigger_i),
    .o_rise  (w_rise)
  );

  // Effective configuration: live inputs while waiting for the trigger (they
  // are being captured on that very edge), the shadow copy once running.
  always_comb begin
    if (r_state == ST_ARMED) begin
      w_delay   = delay_i;
      w_width   = width_i;
      w_num     = num_pulses_i;
      w_spacing = pulse_spacing_i;
    end else begin
      w_delay   = r_delay;
      w_width   = r_width;
      w_num     = r_num;
      w_spacing = r_spacing;
    end
  end

  assign w_no_train     = (w_num == '0) || (w_width == '0);
  assign w_width_load   = cycles_to_phase(PHASE_W'(w_width));
  assign w_spacing_load = cycles_to_phase(PHASE_W'(w_spacing));

  // Next-state and counter logic. The phase counter times every DELAY, PULSE
  // and SPACE interval by counting down to zero; the pulse counter holds the
  // number of pulses still to be started or finished.
  always_comb begin
    w_next_state  = r_state;
    w_next_phase  = (r_phase != '0) ? r_phase - 1'b1 : '0;
    w_next_pulses = r_pulses;
    w_latch       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_next_phase  = '0;
        w_next_pulses = '0;
        if (arm_i) begin
          w_next_state = ST_ARMED;
        end
      end

      ST_ARMED: begin
        w_next_phase  = '0;
        w_next_pulses = '0;
        if (!arm_i) begin
          w_next_state = ST_IDLE;
        end else if (w_rise) begin
          w_latch       = 1'b1;
          w_next_pulses = w_num;
          // A zero delay goes straight to the train so the first pulse
          // starts on the very next edge.
          if (w_delay != '0) begin
            w_next_state = ST_DELAY;
            w_next_phase = cycles_to_phase(w_delay);
          end else if (w_no_train) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_PULSE;
            w_next_phase = w_width_load;
          end
        end
      end

      ST_DELAY: begin
        if (!arm_i) begin
          w_next_state  = ST_IDLE;
          w_next_phase  = '0;
          w_next_pulses = '0;
        end else if (r_phase == '0) begin
          if (w_no_train) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_PULSE;
            w_next_phase = w_width_load;
          end
        end
      end

      ST_PULSE: begin
        if (!arm_i) begin
          w_next_state  = ST_IDLE;
          w_next_phase  = '0;
          w_next_pulses = '0;
        end else if (r_phase == '0) begin
          if (r_pulses <= 1) begin
            w_next_state  = ST_DONE;
            w_next_pulses = '0;
          end else begin
            w_next_pulses = r_pulses - 1'b1;
            // Zero spacing chains pulses back to back into one high run.
            if (w_spacing == '0) begin
              w_next_state = ST_PULSE;
              w_next_phase = w_width_load;
            end else begin
              w_next_state = ST_SPACE;
              w_next_phase = w_spacing_load;
            end
          end
        end
      end

      ST_SPACE: begin
        if (!arm_i) begin
          w_next_state  = ST_IDLE;
          w_next_phase  = '0;
          w_next_pulses = '0;
        end else if (r_phase == '0) begin
          w_next_state = ST_PULSE;
          w_next_phase = w_width_load;
        end
      end

      ST_DONE: begin
        w_next_phase  = '0;
        w_next_pulses = '0;
        w_next_state  = arm_i ? ST_ARMED : ST_IDLE;
      end

      default: begin
        w_next_state  = ST_IDLE;
        w_next_phase  = '0;
        w_next_pulses = '0;
      end
    endcase
  end

  // State, counters and outputs. Outputs are decoded from the next state so
  // they are registered yet line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_pulses <= '0;
      r_glitch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_phase  <= w_next_phase;
      r_pulses <= w_next_pulses;
      r_glitch <= (w_next_state == ST_PULSE);
      r_busy   <= (w_next_state == ST_DELAY) || (w_next_state == ST_PULSE) ||
                  (w_next_state == ST_SPACE);
      r_done   <= (w_next_state == ST_DONE);
    end
  end

  // Shadow configuration captured on the accepted trigger edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_delay   <= '0;
      r_width   <= '0;
      r_num     <= '0;
      r_spacing <= '0;
    end else if (w_latch) begin
      r_delay   <= delay_i;
      r_width   <= width_i;
      r_num     <= num_pulses_i;
      r_spacing <= pulse_spacing_i;
    end
  end

  assign glitch_o = r_glitch;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// tb_glitch_pulse_gen
// Directed bench for glitch_pulse_gen. Expected waveforms are computed from
// the trigger-relative timing: with T the edge where the synchronized rise is
// flagged, pulse p is high on edges T+1+delay+p*(width+spacing) for width
// cycles and done_o follows the final high cycle.
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        triggerIn;
  logic        armIn;
  logic [15:0] delayIn;
  logic [7:0]  widthIn;
  logic [7:0]  numIn;
  logic [15:0] spacingIn;
  logic        glitchOut;
  logic        busyOut;
  logic        doneOut;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  glitch_pulse_gen #(
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trigger_i       (triggerIn),
    .arm_i           (armIn),
    .delay_i         (delayIn),
    .width_i         (widthIn),
    .num_pulses_i    (numIn),
    .pulse_spacing_i (spacingIn),
    .glitch_o        (glitchOut),
    .busy_o          (busyOut),
    .done_o          (doneOut)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drives the four configuration inputs.
  task automatic applyStimulus(input int d, input int w, input int n, input int s);
    delayIn   = 16'(d);
    widthIn   = 8'(w);
    numIn     = 8'(n);
    spacingIn = 16'(s);
  endtask

  // Fires one trigger and checks every output for each cycle of the train and
  // a few cycles beyond. The configuration is scrambled during the train, and
  // optionally the trigger is re-pulsed while busy; neither may have an effect.
  task automatic runTrain(input int d, input int w, input int n, input int s, input bit retrig);
    int   startK;
    int   doneK;
    logic expGlitch;
    applyStimulus(d, w, n, s);
    @(posedge clk);
    #1;
    triggerIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("glitch at T d%0d w%0d n%0d", d, w, n), glitchOut, 1'b0);
    checkOutput($sformatf("busy at T d%0d w%0d n%0d", d, w, n), busyOut, 1'b0);
    startK = 1 + d;
    doneK  = (n == 0 || w == 0) ? 1 + d : startK + (n - 1) * (w + s) + w;
    for (int k = 1; k <= doneK + 3; k++) begin
      @(posedge clk);
      #1;
      expGlitch = 1'b0;
      if (w != 0) begin
        for (int p = 0; p < n; p++) begin
          if (k >= startK + p * (w + s) && k < startK + p * (w + s) + w) expGlitch = 1'b1;
        end
      end
      checkOutput($sformatf("glitch d%0d w%0d n%0d s%0d T+%0d", d, w, n, s, k), glitchOut, expGlitch);
      checkOutput($sformatf("busy d%0d w%0d n%0d s%0d T+%0d", d, w, n, s, k), busyOut, logic'(k < doneK));
      checkOutput($sformatf("done d%0d w%0d n%0d s%0d T+%0d", d, w, n, s, k), doneOut, logic'(k == doneK));
      if (k == 2) begin
        applyStimulus(3, 9, 5, 1);
        if (retrig) triggerIn = 1'b0;
      end
      if (k == 4 && retrig) triggerIn = 1'b1;
    end
    triggerIn = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    armIn     = 1'b0;
    triggerIn = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset glitch", glitchOut, 1'b0);
    checkOutput("reset busy", busyOut, 1'b0);
    checkOutput("reset done", doneOut, 1'b0);
    rst = 1'b0;
    armIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Nominal train, then the boundary shapes.
    runTrain(10, 4, 3, 6, 1'b0);
    runTrain(0, 1, 1, 0, 1'b0);
    runTrain(5, 4, 0, 2, 1'b0);
    runTrain(0, 0, 3, 2, 1'b0);
    runTrain(2, 3, 2, 0, 1'b0);
    runTrain(3, 2, 2, 3, 1'b1);

    // Abort by dropping arm in the middle of the first pulse.
    applyStimulus(2, 5, 3, 4);
    @(posedge clk);
    #1;
    triggerIn = 1'b1;
    repeat (3) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort glitch before drop", glitchOut, 1'b1);
    armIn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort glitch after drop", glitchOut, 1'b0);
    checkOutput("abort busy after drop", busyOut, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("abort no done +%0d", k), doneOut, 1'b0);
      checkOutput($sformatf("abort glitch stays low +%0d", k), glitchOut, 1'b0);
    end
    triggerIn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    armIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset between edges while a pulse is high.
    applyStimulus(3, 4, 2, 2);
    @(posedge clk);
    #1;
    triggerIn = 1'b1;
    repeat (3) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre-reset glitch", glitchOut, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async reset glitch", glitchOut, 1'b0);
    checkOutput("async reset busy", busyOut, 1'b0);
    checkOutput("async reset done", doneOut, 1'b0);
    #1;
    rst = 1'b0;
    triggerIn = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Recovery after reset with arm still held.
    runTrain(1, 2, 2, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
